// File: rtl/spike_delay_detector_pkg.sv
// Shared defaults, parameter-slice index helpers and the per-channel frame state
// for the spike delay detector.
package spike_delay_detector_pkg;

  localparam int N_IN_DEF  = 4;
  localparam int N_OUT_DEF = 2;
  localparam int DW_DEF    = 5;

  typedef struct packed {
    logic                active;
    logic [DW_DEF-1:0]   cnt;
    logic [N_IN_DEF-1:0] hit;
  } frame_t;

  // LSB of channel k's mask slice
  function automatic int mask_base(input int k, input int n_in);
    return k * n_in;
  endfunction

  // LSB of the delay field for channel k, input j
  function automatic int delay_base(input int k, input int j, input int n_in, input int dw);
    return (k * n_in + j) * dw;
  endfunction

endpackage

// File: rtl/spike_delay_detector_if.sv
// Spike bus between the encoders (master) and the detector (slave).
interface spike_delay_detector_if
  import spike_delay_detector_pkg::*;
#(
  parameter int N_IN  = N_IN_DEF,
  parameter int N_OUT = N_OUT_DEF
) ();

  logic [N_OUT-1:0] spike_in;
  logic [N_IN-1:0]  spike;
  logic [N_OUT-1:0] spike_out;

  modport master (output spike_in, output spike, input spike_out);
  modport slave  (input spike_in, input spike, output spike_out);

endinterface

// File: rtl/spike_delay_detector_delay_channel.sv
// One frame tracker: opens on start, checks each masked input against its
// delay window, and pulses det_o the cycle after the pattern completes.
module delay_channel
  import spike_delay_detector_pkg::*;
#(
  parameter int                 N_IN  = N_IN_DEF,
  parameter int                 DW    = DW_DEF,
  parameter int                 WIN   = 16,
  parameter int                 TOL   = 1,
  parameter logic [N_IN-1:0]    MASK  = '0,
  parameter logic [N_IN*DW-1:0] DELAY = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [N_IN-1:0] spike_i,
  output logic            det_o
);

  localparam int            CW    = DW + 1;
  localparam logic [CW-1:0] WIN_C = CW'(WIN);
  localparam logic [CW-1:0] TOL_C = CW'(TOL);

  frame_t          frame_q, frame_d;
  logic            det_q, det_d;
  logic [CW-1:0]   c_s;
  logic [N_IN-1:0] in_win_s, live_s, new_hit_s;
  logic            abort_s, done_s;

  assign c_s = {1'b0, frame_q.cnt} + CW'(1'b1);

  // Window is [max(D-TOL,1), D+TOL] in widened unsigned arithmetic
  for (genvar j = 0; j < N_IN; j++) begin : g_win
    localparam logic [CW-1:0] D  = {1'b0, DELAY[delay_base(0, j, N_IN, DW) +: DW]};
    localparam logic [CW-1:0] LO = (D > TOL_C) ? (D - TOL_C) : CW'(1'b1);
    localparam logic [CW-1:0] HI = D + TOL_C;
    assign in_win_s[j] = (c_s >= LO) && (c_s <= HI);
  end

  assign live_s    = spike_i & MASK & ~frame_q.hit;
  assign new_hit_s = live_s & in_win_s;
  assign abort_s   = frame_q.active && (|(live_s & ~in_win_s));
  assign done_s    = frame_q.active && !abort_s && (MASK != '0)
                     && ((frame_q.hit | new_hit_s) == MASK);

  // Next frame state: a start always reopens the frame, otherwise advance it
  always_comb begin
    frame_d = frame_q;
    det_d   = 1'b0;
    if (start_i) begin
      frame_d.active = 1'b1;
      frame_d.cnt    = '0;
      frame_d.hit    = '0;
    end else if (frame_q.active) begin
      frame_d.cnt = c_s[DW-1:0];
      frame_d.hit = frame_q.hit | new_hit_s;
      if (done_s) begin
        det_d          = 1'b1;
        frame_d.active = 1'b0;
      end else if (abort_s || (c_s >= WIN_C)) begin
        frame_d.active = 1'b0;
      end else begin
        frame_d.active = 1'b1;
      end
    end else begin
      frame_d = frame_q;
    end
  end

  // State and detection pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_q <= '0;
      det_q   <= 1'b0;
    end else begin
      frame_q <= frame_d;
      det_q   <= det_d;
    end
  end

  assign det_o = det_q;

endmodule

// File: rtl/spike_delay_detector.sv
// Temporal spike-pattern detector: one delay_channel per output, each fed its
// slice of the mask and delay templates.
module spike_delay_detector
  import spike_delay_detector_pkg::*;
#(
  parameter int                       N_IN    = N_IN_DEF,
  parameter int                       N_OUT   = N_OUT_DEF,
  parameter int                       DW      = DW_DEF,
  parameter int                       WIN     = 16,
  parameter int                       TOL     = 1,
  parameter logic [N_OUT*N_IN-1:0]    P_MASK  = {4'b0101, 4'b0101},
  parameter logic [N_OUT*N_IN*DW-1:0] P_DELAY = {5'd0, 5'd2, 5'd0, 5'd5,
                                                 5'd0, 5'd4, 5'd0, 5'd2}
) (
  input logic                   clk_i,
  input logic                   rst_i,
  spike_delay_detector_if.slave bus
);

  logic [N_OUT-1:0] det_s;

  for (genvar k = 0; k < N_OUT; k++) begin : g_ch
    delay_channel #(
      .N_IN  (N_IN),
      .DW    (DW),
      .WIN   (WIN),
      .TOL   (TOL),
      .MASK  (P_MASK[mask_base(k, N_IN) +: N_IN]),
      .DELAY (P_DELAY[delay_base(k, 0, N_IN, DW) +: N_IN*DW])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (bus.spike_in[k]),
      .spike_i (bus.spike),
      .det_o   (det_s[k])
    );
  end

  assign bus.spike_out = det_s;

endmodule

// File: tb/tb_spike_delay_detector.sv
// Directed bench for spike_delay_detector; o_spike is checked after every edge.
module tb_spike_delay_detector;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  spike_delay_detector_if bus ();

  spike_delay_detector u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge sample them, then check the output.
  task automatic cyc(input logic r, input logic [1:0] si, input logic [3:0] sp,
                     input logic [1:0] exp_out, input string tag);
    rst          = r;
    bus.spike_in = si;
    bus.spike    = sp;
    @(posedge clk);
    #1;
    n_assert++;
    assert (bus.spike_out === exp_out) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.spike_out, exp_out);
    end
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 4'b0000, 2'b00, tag);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.spike_in = 2'b00;
    bus.spike    = 4'b0000;

    cyc(1'b1, 2'b00, 4'b0000, 2'b00, "reset0");
    cyc(1'b1, 2'b00, 4'b0000, 2'b00, "reset1");
    idle(20, "idle");

    // ch0 pass: in0 at c=2, in2 at c=4
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "ch0_start");
    idle(1, "ch0_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "ch0_in0");
    idle(1, "ch0_c3");
    cyc(1'b0, 2'b00, 4'b0100, 2'b01, "ch0_pulse");
    idle(18, "ch0_after");

    // ch0 tolerance edges: in0 at c=1, in2 at c=5
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "tol_start");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "tol_in0_c1");
    idle(3, "tol_wait");
    cyc(1'b0, 2'b00, 4'b0100, 2'b01, "tol_pulse_c5");
    idle(18, "tol_after");

    // ch0 late in0 at c=4 aborts
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "late_start");
    idle(3, "late_wait");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "late_in0_c4");
    cyc(1'b0, 2'b00, 4'b0100, 2'b00, "late_in2_c5");
    idle(18, "late_after");

    // ch0 early in2 at c=1 aborts, so a later good pair must not fire
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "early_start");
    cyc(1'b0, 2'b00, 4'b0100, 2'b00, "early_in2_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "early_in0_c2");
    idle(1, "early_c3");
    cyc(1'b0, 2'b00, 4'b0100, 2'b00, "early_in2_c4");
    idle(18, "early_after");

    // ch1 pass: in2 at c=2, in0 at c=5
    cyc(1'b0, 2'b10, 4'b0000, 2'b00, "ch1_start");
    idle(1, "ch1_c1");
    cyc(1'b0, 2'b00, 4'b0100, 2'b00, "ch1_in2");
    idle(2, "ch1_wait");
    cyc(1'b0, 2'b00, 4'b0001, 2'b10, "ch1_pulse");
    idle(18, "ch1_after");

    // ch1 unmasked lines are ignored and the frame simply expires
    cyc(1'b0, 2'b10, 4'b0000, 2'b00, "ch1w_start");
    idle(1, "ch1w_c1");
    cyc(1'b0, 2'b00, 4'b0010, 2'b00, "ch1w_in1");
    idle(2, "ch1w_wait");
    cyc(1'b0, 2'b00, 4'b1000, 2'b00, "ch1w_in3");
    idle(18, "ch1w_expire");

    // Retrigger clears hit and count: in2 at new c=1 aborts the fresh frame
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "rt_start");
    idle(1, "rt_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "rt_in0");
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "rt_restart");
    cyc(1'b0, 2'b00, 4'b0100, 2'b00, "rt_in2_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "rt_in0_c2");
    idle(1, "rt_c3");
    cyc(1'b0, 2'b00, 4'b0100, 2'b00, "rt_in2_c4");
    idle(18, "rt_after");

    // Retrigger then a full pattern on the new frame
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "rt2_start");
    idle(1, "rt2_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "rt2_in0");
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "rt2_restart");
    idle(1, "rt2_c1b");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "rt2_in0_c2");
    idle(1, "rt2_c3");
    cyc(1'b0, 2'b00, 4'b0100, 2'b01, "rt2_pulse");
    idle(18, "rt2_after");

    // Partial frame with only in0 expires with no pulse
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "exp_start");
    idle(1, "exp_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "exp_in0");
    idle(18, "exp_wait");

    // Both channels start; ch1 aborts on in0 at c=2, ch0 completes
    cyc(1'b0, 2'b11, 4'b0000, 2'b00, "both_start");
    idle(1, "both_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "both_in0");
    idle(1, "both_c3");
    cyc(1'b0, 2'b00, 4'b0100, 2'b01, "both_ch0_pulse");
    idle(2, "both_c5");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "both_ch1_dead");
    idle(18, "both_after");

    // Reset overrides a start in the same cycle
    cyc(1'b1, 2'b01, 4'b0000, 2'b00, "rst_start");
    idle(1, "rst_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "rst_in0");
    idle(1, "rst_c3");
    cyc(1'b0, 2'b00, 4'b0100, 2'b00, "rst_no_frame");
    idle(18, "rst_after");

    // Reset overrides the completing cycle
    cyc(1'b0, 2'b01, 4'b0000, 2'b00, "rstc_start");
    idle(1, "rstc_c1");
    cyc(1'b0, 2'b00, 4'b0001, 2'b00, "rstc_in0");
    idle(1, "rstc_c3");
    cyc(1'b1, 2'b00, 4'b0100, 2'b00, "rstc_complete");
    idle(4, "rstc_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
